// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: small in-order FIFO between FP decode and the FPU.
// The head entry is presented combinationally to the FPU. It is held while the
// FPU reports a hazard on it, and it is popped in the same cycle that is_legl is high.
// Cycles stalled by a hazard on a valid head are counted in a saturating counter.
module fpu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_ival,
    input  logic              hazard,
    output logic              is_legl,
    output logic [31:0]       inst,
    output logic [31:0]       from_intreg,
    output logic [ADDR_W:0]   count,
    output logic              issued,
    output logic [31:0]       stall_cnt
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              not_empty;
    logic              push;
    logic              pop;

    // Full/empty come from registered occupancy only, so in_ready has no path from hazard.
    assign not_empty = (count != '0);
    assign in_ready  = (count != FULL_COUNT);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = not_empty & ~hazard & ~flush;
    assign is_legl   = pop;
    assign issued    = pop;

    // Present the head entry, or zeros when nothing is queued.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        inst        = 32'h0;
        from_intreg = 32'h0;
        if (not_empty) begin
            inst        = mem[rd_ptr][63:32];
            from_intreg = mem[rd_ptr][31:0];
        end
    end

    // Entry storage: written on an accepted push.
    // NOTE: the data array is deliberately not reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_inst, in_ival};
        end
    end

    // Pointers and occupancy: flush empties the queue and drops any same-cycle push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of cycles where a valid head is held by a hazard; survives flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (not_empty && hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue: a behavioural queue model acts as the
// scoreboard (entries pushed when stimulus is accepted, popped when the head issues),
// plus a table of hand-derived vectors for the fill/stall/drain sequence.
module tb_fpu_issue_queue;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_ival;
    logic        hazard;
    logic        is_legl;
    logic [31:0] inst;
    logic [31:0] from_intreg;
    logic [2:0]  count;
    logic        issued;
    logic [31:0] stall_cnt;

    fpu_issue_queue #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_ival     (in_ival),
        .hazard      (hazard),
        .is_legl     (is_legl),
        .inst        (inst),
        .from_intreg (from_intreg),
        .count       (count),
        .issued      (issued),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] ival;
    } entry_t;

    typedef struct {
        logic        v;
        logic [31:0] i;
        logic [31:0] iv;
        logic        hz;
        logic        exp_legl;
        logic [31:0] exp_count;
        logic        exp_ready;
        logic [31:0] exp_inst;
        logic [31:0] exp_stall;
    } vec_t;

    entry_t      sb[$];
    logic [31:0] m_stall;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive after the falling edge, compare just before the rising edge,
    // then advance the model to the post-edge state.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] iv,
                         input logic hz, input logic fl);
        logic        exp_legl;
        logic        accept;
        entry_t      e;
        @(negedge clk);
        in_valid = v;
        in_inst  = i;
        in_ival  = iv;
        hazard   = hz;
        flush    = fl;
        #4;
        exp_legl = (sb.size() != 0) && !hz && !fl;
        accept   = v && (sb.size() != 4) && !fl;
        check("in_ready", 32'(in_ready), 32'(sb.size() != 4));
        check("count", 32'(count), 32'(sb.size()));
        check("stall_cnt", stall_cnt, m_stall);
        check("is_legl", 32'(is_legl), 32'(exp_legl));
        check("issued", 32'(issued), 32'(exp_legl));
        if (sb.size() != 0) begin
            check("head_inst", inst, sb[0].inst);
            check("head_ival", from_intreg, sb[0].ival);
        end else begin
            check("empty_inst", inst, 32'h0);
            check("empty_ival", from_intreg, 32'h0);
        end
        if ((sb.size() != 0) && hz && (m_stall != 32'hFFFF_FFFF)) begin
            m_stall = m_stall + 32'd1;
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (exp_legl) begin
                void'(sb.pop_front());
            end
            if (accept) begin
                e.inst = i;
                e.ival = iv;
                sb.push_back(e);
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        checks   = 0;
        errors   = 0;
        m_stall  = 32'd0;
        rstn     = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_inst  = 32'h0;
        in_ival  = 32'h0;
        hazard   = 1'b0;

        // Fill with hazard held, then drain in order.
        vecs[0] = '{1'b1, 32'hA000_0001, 32'h1111_0001, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0,         32'd0};
        vecs[1] = '{1'b1, 32'hA000_0002, 32'h1111_0002, 1'b1, 1'b0, 32'd1, 1'b1, 32'hA000_0001, 32'd0};
        vecs[2] = '{1'b1, 32'hA000_0003, 32'h1111_0003, 1'b1, 1'b0, 32'd2, 1'b1, 32'hA000_0001, 32'd1};
        vecs[3] = '{1'b1, 32'hA000_0004, 32'h1111_0004, 1'b1, 1'b0, 32'd3, 1'b1, 32'hA000_0001, 32'd2};
        vecs[4] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'd4, 1'b0, 32'hA000_0001, 32'd3};
        vecs[5] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'd4, 1'b0, 32'hA000_0001, 32'd4};
        vecs[6] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'd3, 1'b1, 32'hA000_0002, 32'd4};
        vecs[7] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'd2, 1'b1, 32'hA000_0003, 32'd4};
        vecs[8] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'd1, 1'b1, 32'hA000_0004, 32'd4};
        vecs[9] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0, 1'b1, 32'h0,         32'd4};

        // Reset state.
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_legl", 32'(is_legl), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_stall", stall_cnt, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Table: fill/stall/drain.
        for (int k = 0; k < 10; k++) begin
            cycle(vecs[k].v, vecs[k].i, vecs[k].iv, vecs[k].hz, 1'b0);
            check($sformatf("vec%0d_legl", k), 32'(is_legl), 32'(vecs[k].exp_legl));
            check($sformatf("vec%0d_count", k), 32'(count), vecs[k].exp_count);
            check($sformatf("vec%0d_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
            check($sformatf("vec%0d_inst", k), inst, vecs[k].exp_inst);
            check($sformatf("vec%0d_stall", k), stall_cnt, vecs[k].exp_stall);
        end

        // Stall hold: head held three hazard cycles, then issues once.
        cycle(1'b1, 32'h0020_F053, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            check("hold_inst", inst, 32'h0020_F053);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("hold_issue", {31'b0, is_legl}, 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("hold_once", 32'(count), 32'd0);
        check("hold_stall", stall_cnt, 32'd7);

        // Push while head issues at count=2.
        cycle(1'b1, 32'hB000_0001, 32'h2222_0001, 1'b1, 1'b0);
        cycle(1'b1, 32'hB000_0002, 32'h2222_0002, 1'b1, 1'b0);
        cycle(1'b1, 32'hB000_0003, 32'h2222_0003, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("pp_count", 32'(count), 32'd2);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        // Wrap: continuous push/pop, pointers go around more than twice.
        for (int k = 0; k < 11; k++) begin
            cycle(1'b1, 32'hC000_0000 + 32'(k), 32'h3333_0000 + 32'(k * 7), 1'b0, 1'b0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Flush at count=3 with a push offered.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'hD000_0000 + 32'(k), 32'h4444_0000 + 32'(k), 1'b1, 1'b0);
        end
        cycle(1'b1, 32'hD000_00FF, 32'h4444_00FF, 1'b0, 1'b1);
        check("flush_legl", 32'(is_legl), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_inst", inst, 32'h0);

        // Asynchronous reset mid-traffic at count=3.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'hE000_0000 + 32'(k), 32'h5555_0000 + 32'(k), 1'b1, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        hazard   = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_legl", 32'(is_legl), 32'd0);
        check("arst_inst", inst, 32'h0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_stall", stall_cnt, 32'd0);
        sb.delete();
        m_stall = 32'd0;
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 32'hF000_0001, 32'h6666_0001, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
